// File: rtl/byte_pack_pkg.sv
// Shared constants and helpers for the byte-to-word packing FIFO.
package byte_pack_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int LANES  = 4;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  localparam int LANE_IDX_W = clog2(LANES);

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

endpackage

// File: rtl/byte_pack_fifo_if.sv
// Byte-in / word-out bus of the packing FIFO; master drives bytes and reads, slave is the FIFO.
interface byte_pack_fifo_if #(
  parameter int AW = 3
);
  import byte_pack_pkg::*;

  logic              en_w;
  logic [BYTE_W-1:0] data_in;
  logic              flush;
  logic              en_r;
  logic [WORD_W-1:0] data_out;
  logic              rd_valid;
  logic              w_ready;
  logic              full_flag;
  logic              empty_flag;
  lane_idx_t         byte_cnt;
  logic [AW:0]       word_cnt;
  logic              ovf;
  logic              udf;

  modport master (
    output en_w, data_in, flush, en_r,
    input  data_out, rd_valid, w_ready, full_flag, empty_flag,
           byte_cnt, word_cnt, ovf, udf
  );

  modport slave (
    input  en_w, data_in, flush, en_r,
    output data_out, rd_valid, w_ready, full_flag, empty_flag,
           byte_cnt, word_cnt, ovf, udf
  );

endinterface

// File: rtl/sync_word_fifo.sv
// DEPTH x 32 synchronous word FIFO with registered read data and a refused-read pulse.
module sync_word_fifo
  import byte_pack_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic              udf
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              wr_ok;
  logic              rd_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      udf      <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      udf      <= rd_en && empty;
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_ok) begin
        rd_data <= mem[rptr];
        rptr    <= rptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/byte_pack_fifo.sv
// Packs little-endian bytes into 32-bit words and queues them in a word FIFO; flush commits a zero-padded partial word.
module byte_pack_fifo
  import byte_pack_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic              clk,
  input logic              rst,
  byte_pack_fifo_if.slave  bus
);

  logic [LANES-1:0][BYTE_W-1:0] lanes;
  lane_idx_t                    byte_cnt;
  logic                         full;
  logic                         empty;
  logic                         w_ready;
  logic                         accept;
  logic                         last_byte;
  logic                         wants_flush;
  logic                         flush_ok;
  logic                         flush_drop;
  logic                         commit;
  logic                         ovf;
  logic [WORD_W-1:0]            commit_word;

  assign w_ready     = !(full && byte_cnt == lane_idx_t'(LANES-1));
  assign accept      = bus.en_w && w_ready;
  assign last_byte   = accept && byte_cnt == lane_idx_t'(LANES-1);
  assign wants_flush = bus.flush && (byte_cnt != '0 || accept);
  assign flush_ok    = wants_flush && !full;
  assign flush_drop  = wants_flush && full;
  assign commit      = last_byte || flush_ok;

  // Held lanes below byte_cnt, the incoming byte in lane byte_cnt, zeros above.
  always_comb begin
    commit_word = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(byte_cnt)) begin
        commit_word[i*BYTE_W +: BYTE_W] = lanes[i];
      end else if (i == int'(byte_cnt) && accept) begin
        commit_word[i*BYTE_W +: BYTE_W] = bus.data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !commit) begin
      lanes[byte_cnt] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      ovf <= (bus.en_w && !w_ready) || flush_drop;
      if (commit) begin
        byte_cnt <= '0;
      end else if (accept) begin
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

  sync_word_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_word_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (commit),
    .wr_data  (commit_word),
    .rd_en    (bus.en_r),
    .rd_data  (bus.data_out),
    .rd_valid (bus.rd_valid),
    .full     (full),
    .empty    (empty),
    .count    (bus.word_cnt),
    .udf      (bus.udf)
  );

  assign bus.w_ready    = w_ready;
  assign bus.full_flag  = full;
  assign bus.empty_flag = empty;
  assign bus.byte_cnt   = byte_cnt;
  assign bus.ovf        = ovf;

endmodule
